// File: rtl/addsub_arbiter16.sv
// Two-requester round-robin front end for one shared 16-bit parallel-prefix adder.
// Supports ADD/SUB/NEG/ABS; SUB takes two adder passes (negate b, then add).
module addsub_arbiter16 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [1:0]  req0_op_i,
  input  logic [15:0] req0_a_i,
  input  logic [15:0] req0_b_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [1:0]  req1_op_i,
  input  logic [15:0] req1_a_i,
  input  logic [15:0] req1_b_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [15:0] rsp_data_o,
  output logic        rsp_cout_o,
  output logic        rsp_ovf_o,
  output logic        busy_o,
  output logic [15:0] ops_done_o
);

  typedef enum logic [1:0] {S_IDLE, S_NEG, S_ADD, S_RESP} state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ABS = 2'b11;

  // Kogge-Stone style recursive-doubling carry network, carry-in fixed at 0.
  function automatic logic [16:0] ks_add(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] g, p, gn, pn, h;
    g = x & y;
    p = x ^ y;
    h = p;
    for (int d = 1; d < 16; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < 16; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    return {g[15], h ^ {g[14:0], 1'b0}};
  endfunction

  state_e      state_q, state_d;
  logic        prio_q;
  logic [1:0]  op_q;
  logic [15:0] a_q, b_q, nb_q;
  logic        id_q;
  logic        rsp_id_q, rsp_cout_q, rsp_ovf_q;
  logic [15:0] rsp_data_q, ops_done_q;

  logic        grant, accept;
  logic [1:0]  sel_op;
  logic [15:0] add_x, add_y, sum, res_d;
  logic        sum_cout, ovf_d;

  assign accept = (state_q == S_IDLE) && (req0_valid_i || req1_valid_i);
  assign grant  = (req0_valid_i && req1_valid_i) ? prio_q : req1_valid_i;
  assign sel_op = grant ? req1_op_i : req0_op_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (sel_op == OP_ADD) ? S_ADD : S_NEG;
      S_NEG:  state_d = (op_q == OP_SUB) ? S_ADD : S_RESP;
      S_ADD:  state_d = S_RESP;
      S_RESP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready_o = accept && !grant;
    req1_ready_o = accept && grant;
    busy_o       = (state_q != S_IDLE);
    rsp_valid_o  = (state_q == S_RESP);
    add_x        = 16'h0000;
    add_y        = 16'h0000;
    case (state_q)
      S_NEG: begin
        add_x = ~((op_q == OP_SUB) ? b_q : a_q);
        add_y = 16'h0001;
      end
      S_ADD: begin
        add_x = a_q;
        add_y = (op_q == OP_SUB) ? nb_q : b_q;
      end
      default: ;
    endcase
  end

  assign {sum_cout, sum} = ks_add(add_x, add_y);

  always_comb begin
    res_d = sum;
    if (state_q == S_NEG && op_q == OP_ABS && !a_q[15]) res_d = a_q;
    case (op_q)
      OP_ADD:  ovf_d = (a_q[15] == b_q[15]) && (sum[15] != a_q[15]);
      OP_SUB:  ovf_d = (a_q[15] != b_q[15]) && (sum[15] != a_q[15]);
      default: ovf_d = (a_q == 16'h8000);
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q     <= 1'b0;
      op_q       <= 2'b00;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      nb_q       <= 16'h0000;
      id_q       <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_data_q <= 16'h0000;
      rsp_cout_q <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      ops_done_q <= 16'h0000;
    end else begin
      if (accept) begin
        op_q   <= sel_op;
        a_q    <= grant ? req1_a_i : req0_a_i;
        b_q    <= grant ? req1_b_i : req0_b_i;
        id_q   <= grant;
        prio_q <= ~grant;
      end
      if (state_q == S_NEG && op_q == OP_SUB) begin
        nb_q <= sum;
      end else if (state_q == S_NEG || state_q == S_ADD) begin
        rsp_id_q   <= id_q;
        rsp_data_q <= res_d;
        rsp_cout_q <= sum_cout;
        rsp_ovf_q  <= ovf_d;
      end
      if (state_q == S_RESP && rsp_ready_i) ops_done_q <= ops_done_q + 16'd1;
    end
  end

  assign rsp_id_o   = rsp_id_q;
  assign rsp_data_o = rsp_data_q;
  assign rsp_cout_o = rsp_cout_q;
  assign rsp_ovf_o  = rsp_ovf_q;
  assign ops_done_o = ops_done_q;

endmodule

// File: tb/tb_addsub_arbiter16.sv
// Directed bench for addsub_arbiter16: single ops, arbitration, backpressure, reset.
module tb_addsub_arbiter16;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, rdy0, rdy1;
  logic [1:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf, busy;
  logic [15:0] rsp_data, ops_done;

  int total = 0;
  int bad   = 0;
  int ops_exp = 0;

  always #5 clk = ~clk;

  addsub_arbiter16 dut (
    .clk_i(clk), .rst_i(rst),
    .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_op_i(op0), .req0_a_i(a0), .req0_b_i(b0),
    .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_op_i(op1), .req1_a_i(a1), .req1_b_i(b1),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_data), .rsp_cout_o(rsp_cout), .rsp_ovf_o(rsp_ovf),
    .busy_o(busy), .ops_done_o(ops_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op from an idle, negedge-aligned start and check its response.
  task automatic run_op(input logic id, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] ed, input logic ec,
                        input logic eo, input int passes, input string tag);
    int lat;
    if (id) begin v1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else    begin v0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    #1;
    chk({tag, ".ready"}, {rdy1, rdy0}, id ? 2'b10 : 2'b01);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin v0 = 1'b0; v1 = 1'b0; end
    end while (!rsp_valid && lat < 10);
    chk({tag, ".lat"}, lat, passes + 1);
    chk({tag, ".data"}, rsp_data, ed);
    chk({tag, ".cout"}, rsp_cout, ec);
    chk({tag, ".ovf"}, rsp_ovf, eo);
    chk({tag, ".id"}, rsp_id, id);
    ops_exp++;
    @(negedge clk);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".ops"}, ops_done, ops_exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic        ids [8];
    int          n0, n1, nresp, both, pulse, lat, seen;
    logic        p0, p1;
    logic [15:0] held;

    rst = 1'b1; v0 = 0; v1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst.valid", rsp_valid, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.ops", ops_done, 16'h0);
    chk("rst.data", rsp_data, 16'h0);
    chk("rst.ready", {rdy1, rdy0}, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b0, 2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1, "add_ovf");
    run_op(1'b1, 2'b01, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0, 2, "sub_5_3");
    run_op(1'b1, 2'b01, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b1, 2, "sub_ovf");
    run_op(1'b0, 2'b10, 16'h0001, 16'h5555, 16'hFFFF, 1'b0, 1'b0, 1, "neg_1");
    run_op(1'b0, 2'b10, 16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b1, 1, "neg_min");
    run_op(1'b1, 2'b11, 16'hFFFB, 16'h0000, 16'h0005, 1'b0, 1'b0, 1, "abs_neg");
    run_op(1'b0, 2'b11, 16'h1234, 16'hAAAA, 16'h1234, 1'b0, 1'b0, 1, "abs_pos");
    run_op(1'b1, 2'b10, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1, "neg_0");
    run_op(1'b0, 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1, "add_wrap");

    // Arbitration from a fresh reset: grants must alternate starting at 0.
    rst = 1'b1; @(negedge clk); rst = 1'b0; ops_exp = 0;
    v0 = 1'b1; op0 = 2'b00; a0 = 16'h0010; b0 = 16'h0001;
    v1 = 1'b1; op1 = 2'b00; a1 = 16'h0100; b1 = 16'h0001;
    n0 = 0; n1 = 0; nresp = 0; both = 0; pulse = 0; p0 = 0; p1 = 0;
    for (int cyc = 0; cyc < 80 && nresp < 8; cyc++) begin
      @(negedge clk);
      if (p0) begin n0++; if (n0 == 4) v0 = 1'b0; else a0 = a0 + 16'd1; end
      if (p1) begin n1++; if (n1 == 4) v1 = 1'b0; else a1 = a1 + 16'd1; end
      #1;
      if (rdy0 && rdy1) both++;
      if ((rdy0 && p0) || (rdy1 && p1)) pulse++;
      p0 = rdy0; p1 = rdy1;
      if (rsp_valid && nresp < 8) begin ids[nresp] = rsp_id; nresp++; end
    end
    chk("arb.nresp", nresp, 8);
    chk("arb.both_ready", both, 0);
    chk("arb.pulse", pulse, 0);
    for (int i = 0; i < 8; i++) chk($sformatf("arb.id%0d", i), ids[i], i % 2);
    @(negedge clk);
    ops_exp = 8;
    chk("arb.ops", ops_done, ops_exp);

    // Backpressure: req0 ADD held in RESP while req1 waits.
    rsp_ready = 1'b0;
    v0 = 1'b1; op0 = 2'b00; a0 = 16'h1111; b0 = 16'h2222;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b1; op1 = 2'b00; a1 = 16'h0002; b1 = 16'h0003;
    lat = 0;
    while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
    chk("bp.valid_seen", rsp_valid, 1'b1);
    held = rsp_data;
    chk("bp.data", held, 16'h3333);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp.hold%0d", i), {rsp_valid, busy, rdy0, rdy1, rsp_data, 3'b000, rsp_id},
          {1'b1, 1'b1, 1'b0, 1'b0, 16'h3333, 3'b000, 1'b0});
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp.hs_no_ready", rdy1, 1'b0);
    @(negedge clk);
    #1;
    ops_exp++;
    chk("bp.idle", {rsp_valid, busy}, 2'b00);
    chk("bp.ops", ops_done, ops_exp);
    chk("bp.next_ready", rdy1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
    chk("bp.next_lat", lat, 2);
    chk("bp.next_data", rsp_data, 16'h0005);
    chk("bp.next_id", rsp_id, 1'b1);
    @(negedge clk);
    ops_exp++;
    chk("bp.next_ops", ops_done, ops_exp);

    // Reset during the NEG pass of a SUB.
    v0 = 1'b1; op0 = 2'b01; a0 = 16'h0005; b0 = 16'h0003;
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    chk("rmid.busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rmid.outputs", {rsp_valid, busy, rsp_cout, rsp_ovf, rsp_id, rsp_data},
        {5'b00000, 16'h0000});
    chk("rmid.ops", ops_done, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) seen++; end
    chk("rmid.no_rsp", seen, 0);
    chk("rmid.ops_after", ops_done, 16'h0);
    ops_exp = 0;
    v0 = 1'b1; op0 = 2'b00; a0 = 16'h0001; b0 = 16'h0002;
    v1 = 1'b1; op1 = 2'b00; a1 = 16'h0003; b1 = 16'h0004;
    #1;
    chk("rmid.grant0", {rdy1, rdy0}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin @(negedge clk); lat++; end
    chk("rmid.first_id", rsp_id, 1'b0);
    chk("rmid.first_data", rsp_data, 16'h0003);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
